// File: rtl/axi_lite_arbiter.sv
// N-to-1 AXI-Lite arbiter: independent round-robin write and read paths toward one
// shared slave, one outstanding transaction per direction.
module axi_lite_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 48,
    parameter int unsigned DATA_WIDTH  = 64,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_MASTERS-1:0]            m_aw_valid,
    output logic [NUM_MASTERS-1:0]            m_aw_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_aw_addr,
    input  logic [NUM_MASTERS*3-1:0]          m_aw_prot,
    input  logic [NUM_MASTERS-1:0]            m_w_valid,
    output logic [NUM_MASTERS-1:0]            m_w_ready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_w_data,
    input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_w_strb,
    output logic [NUM_MASTERS-1:0]            m_b_valid,
    input  logic [NUM_MASTERS-1:0]            m_b_ready,
    output logic [NUM_MASTERS*2-1:0]          m_b_resp,
    input  logic [NUM_MASTERS-1:0]            m_ar_valid,
    output logic [NUM_MASTERS-1:0]            m_ar_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ar_addr,
    input  logic [NUM_MASTERS*3-1:0]          m_ar_prot,
    output logic [NUM_MASTERS-1:0]            m_r_valid,
    input  logic [NUM_MASTERS-1:0]            m_r_ready,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_r_data,
    output logic [NUM_MASTERS*2-1:0]          m_r_resp,
    output logic                              s_aw_valid,
    input  logic                              s_aw_ready,
    output logic [ADDR_WIDTH-1:0]             s_aw_addr,
    output logic [2:0]                        s_aw_prot,
    output logic                              s_w_valid,
    input  logic                              s_w_ready,
    output logic [DATA_WIDTH-1:0]             s_w_data,
    output logic [STRB_WIDTH-1:0]             s_w_strb,
    input  logic                              s_b_valid,
    output logic                              s_b_ready,
    input  logic [1:0]                        s_b_resp,
    output logic                              s_ar_valid,
    input  logic                              s_ar_ready,
    output logic [ADDR_WIDTH-1:0]             s_ar_addr,
    output logic [2:0]                        s_ar_prot,
    input  logic                              s_r_valid,
    output logic                              s_r_ready,
    input  logic [DATA_WIDTH-1:0]             s_r_data,
    input  logic [1:0]                        s_r_resp
);

    localparam int unsigned GW = $clog2(NUM_MASTERS);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [1:0]    w_state, r_state;
    logic [GW-1:0] wgrant, rgrant, wlast, rlast;
    logic          aw_done, w_done;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // First requester strictly after the previous winner, wrapping past NUM_MASTERS-1.
    function automatic logic [GW-1:0] rr_next(input logic [NUM_MASTERS-1:0] req,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = 32'(last) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && req[idx[GW-1:0]]) begin
                pick  = idx[GW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign aw_hs = s_aw_valid & s_aw_ready;
    assign w_hs  = s_w_valid & s_w_ready;
    assign b_hs  = s_b_valid & s_b_ready;
    assign ar_hs = s_ar_valid & s_ar_ready;
    assign r_hs  = s_r_valid & s_r_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            wgrant  <= '0;
            wlast   <= GW'(NUM_MASTERS - 1);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (|m_aw_valid) begin
                    wgrant  <= rr_next(m_aw_valid, wlast);
                    w_state <= W_ADDR;
                end
                W_ADDR: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        w_state <= W_RESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                W_RESP: if (b_hs) begin
                    wlast   <= wgrant;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            rgrant  <= '0;
            rlast   <= GW'(NUM_MASTERS - 1);
        end else begin
            case (r_state)
                R_IDLE: if (|m_ar_valid) begin
                    rgrant  <= rr_next(m_ar_valid, rlast);
                    r_state <= R_ADDR;
                end
                R_ADDR: if (ar_hs) r_state <= R_DATA;
                R_DATA: if (r_hs) begin
                    rlast   <= rgrant;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        s_aw_valid = 1'b0;
        s_w_valid  = 1'b0;
        s_b_ready  = 1'b0;
        m_aw_ready = '0;
        m_w_ready  = '0;
        m_b_valid  = '0;
        m_b_resp   = '0;
        s_aw_addr  = m_aw_addr[wgrant*ADDR_WIDTH +: ADDR_WIDTH];
        s_aw_prot  = m_aw_prot[wgrant*3 +: 3];
        s_w_data   = m_w_data[wgrant*DATA_WIDTH +: DATA_WIDTH];
        s_w_strb   = m_w_strb[wgrant*STRB_WIDTH +: STRB_WIDTH];
        case (w_state)
            W_ADDR: begin
                s_aw_valid         = m_aw_valid[wgrant] & ~aw_done;
                s_w_valid          = m_w_valid[wgrant] & ~w_done;
                m_aw_ready[wgrant] = s_aw_ready & ~aw_done;
                m_w_ready[wgrant]  = s_w_ready & ~w_done;
            end
            W_RESP: begin
                s_b_ready              = m_b_ready[wgrant];
                m_b_valid[wgrant]      = s_b_valid;
                m_b_resp[wgrant*2 +: 2] = s_b_resp;
            end
            default: ;
        endcase
    end

    always_comb begin
        s_ar_valid = 1'b0;
        s_r_ready  = 1'b0;
        m_ar_ready = '0;
        m_r_valid  = '0;
        m_r_data   = '0;
        m_r_resp   = '0;
        s_ar_addr  = m_ar_addr[rgrant*ADDR_WIDTH +: ADDR_WIDTH];
        s_ar_prot  = m_ar_prot[rgrant*3 +: 3];
        case (r_state)
            R_ADDR: begin
                s_ar_valid         = m_ar_valid[rgrant];
                m_ar_ready[rgrant] = s_ar_ready;
            end
            R_DATA: begin
                s_r_ready                           = m_r_ready[rgrant];
                m_r_valid[rgrant]                   = s_r_valid;
                m_r_data[rgrant*DATA_WIDTH +: DATA_WIDTH] = s_r_data;
                m_r_resp[rgrant*2 +: 2]             = s_r_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of requesting AXI-Lite masters, range 2..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 48: address width on every port.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: data width on every port; STRB_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 m_aw_valid in N, m_aw_ready out N, m_aw_addr in N*ADDR_WIDTH, m_aw_prot in N*3: per-master AW channel; slice i belongs to master i.
REQ-008 m_w_valid in N, m_w_ready out N, m_w_data in N*DATA_WIDTH, m_w_strb in N*STRB_WIDTH: per-master W channel.
REQ-009 m_b_valid out N, m_b_ready in N, m_b_resp out N*2: per-master B channel.
REQ-010 m_ar_valid in N, m_ar_ready out N, m_ar_addr in N*ADDR_WIDTH, m_ar_prot in N*3: per-master AR channel.
REQ-011 m_r_valid out N, m_r_ready in N, m_r_data out N*DATA_WIDTH, m_r_resp out N*2: per-master R channel.
REQ-012 s_aw_*, s_w_*, s_b_*, s_ar_*, s_r_*: one AXI-Lite master port toward the shared slave, same signals at single width, opposite directions.

Function
REQ-013 Write and read paths SHALL be arbitrated independently; one outstanding write and one outstanding read at most.
REQ-014 Write FSM SHALL have states W_IDLE, W_ADDR, W_RESP.
REQ-015 In W_IDLE with any m_aw_valid set, SHALL register wgrant by round-robin: first requester at index > last write winner, wrapping at NUM_MASTERS-1 to 0; enter W_ADDR next cycle.
REQ-016 In W_ADDR, s_aw_valid SHALL equal m_aw_valid[wgrant] & !aw_done and s_w_valid equal m_w_valid[wgrant] & !w_done; payloads muxed from wgrant.
REQ-017 m_aw_ready[wgrant] SHALL equal s_aw_ready & !aw_done; m_w_ready[wgrant] equal s_w_ready & !w_done; all other masters' ready bits SHALL be 0.
REQ-018 aw_done/w_done SHALL set on their handshake; AW and W may complete in either order or the same cycle; when both done, enter W_RESP and clear both.
REQ-019 In W_RESP, s_b_valid/s_b_resp SHALL route only to m_b_valid[wgrant]/m_b_resp slice; s_b_ready = m_b_ready[wgrant]; on handshake, last write winner := wgrant, enter W_IDLE.
REQ-020 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA with identical round-robin (own pointer), AR forwarded in R_ADDR, R routed to rgrant in R_DATA, return to R_IDLE on R handshake.
REQ-021 Grant latency SHALL be one cycle: request sampled in IDLE, slave valid earliest next cycle; back-to-back transactions incur one IDLE cycle each.
REQ-022 Grant SHALL NOT change between IDLE exit and response handshake regardless of other masters' requests.
REQ-023 Non-granted masters SHALL see ready=0 and valid=0 on all their channels.
REQ-024 A W beat presented before its AW wins arbitration SHALL stall, not be forwarded.
REQ-025 With a single requester, that requester SHALL be granted every transaction.

Reset
REQ-026 While rstn=0: both FSMs IDLE, aw_done=w_done=0, last winners = NUM_MASTERS-1 (master 0 highest priority), all s_*_valid, s_*_ready, m_*_valid, m_*_ready outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it immediately; no response is delivered after rstn rises.

Verification
REQ-028 Masters 0 and 1 assert AW+W same cycle after reset -> master 0 granted, s_aw_valid high next cycle; after B, master 1 granted next.
REQ-029 Granted master: slave accepts W 3 cycles before AW -> exactly one W and one AW handshake at slave, then W_RESP.
REQ-030 Slave returns b_resp=2'b10 with master 1 granted -> m_b_valid=2'b10, m_b_resp slice 1 = 2'b10, slice 0 valid low.
REQ-031 Concurrent write by master 0 and read by master 1 -> both forwarded in parallel, responses routed independently.
REQ-032 NUM_MASTERS=4, all requesting continuously -> grant order 0,1,2,3,0; no master starved.
REQ-033 rstn low during R_DATA -> all outputs 0 within reset; first post-reset read grants master 0.
